fetch_align: RTL and testbench

//  Instruction aligner directly downstream of the PC generator / ISRAM read port.
//  - Takes the 64-bit ISRAM line returned one cycle after a chip-select and extracts
//    the instruction at the current pc, either 16-bit compressed or 32-bit.
//  - Keeps the last line so that fetches inside the same 8-byte line need no re-read.
//  - Stitches 32-bit instructions that start at pc[2:1]==2'b11 across two lines.
//  - Drives rv32_instr/isrv16 combinationally into the PC generator's mini-decode.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fa_hw_sel.sv | 16 +
 rtl/fetch_align.sv | 108 ++++++++++
 tb/tb_fetch_align.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and line-source record for the fetch aligner.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [28:0] RST_ADR   = 29'h0;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CROSS = 1'b1
   } state_e;

   // One 8-byte ISRAM line with its line address and valid flag
   typedef struct packed {
      logic [63:0] data;
      logic [28:0] tag;
      logic        vld;
   } line_t;

   function automatic logic is_rv16(input logic [15:0] hw);
      return hw[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/fa_hw_sel.sv
// Halfword/word selector: picks the 16-bit half and the 32-bit word starting at idx.
module fa_hw_sel (
   input  logic [63:0] line,
   input  logic [1:0]  idx,
   output logic [15:0] lo,
   output logic [31:0] word
);

   // Zero-extended so idx==3 stays in range; that word is never used as a full instruction
   logic [79:0] ext;

   assign ext  = {16'h0, line};
   assign lo   = line[{idx, 4'b0000} +: 16];
   assign word = ext[{1'b0, idx, 4'b0000} +: 32];

endmodule

// File: rtl/fetch_align.sv
// Instruction aligner: extracts 16/32-bit instructions at pc from the fresh or buffered
// ISRAM line and stitches 32-bit instructions that straddle two lines.
module fetch_align
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
   parameter logic [28:0] RST_ADR   = fetch_pkg::RST_ADR
) (
   input  logic        clk,
   input  logic        cpurst_n,
   input  logic [31:0] pc,
   input  logic [63:0] isram_rdata,
   input  logic        isram_cs_ff,
   input  logic [28:0] isram_adr_ff,
   input  logic        fet_flush,
   input  logic        branch_predict_err,
   input  logic        pipe_hold,
   output logic [31:0] rv32_instr,
   output logic        isrv16,
   output logic        inst_valid,
   output logic        fetch_misalign,
   output logic        cross_wait
);

   line_t       line_q;
   line_t       src;
   state_e      state_q;
   logic [15:0] hold_hw_q;
   logic [15:0] lo;
   logic [31:0] word;
   logic [28:0] next_tag;
   logic        hit;
   logic        xhit;
   logic        drop;
   logic        cross_go;

   assign src      = isram_cs_ff ? {isram_rdata, isram_adr_ff, 1'b1} : line_q;
   assign next_tag = pc[31:3] + 29'd1;
   assign hit      = src.vld & (src.tag == pc[31:3]);
   assign xhit     = src.vld & (src.tag == next_tag);
   assign drop     = branch_predict_err | fet_flush;
   assign cross_go = (state_q == S_IDLE) & ~pc[0] & hit & ~is_rv16(lo) & (pc[2:1] == 2'b11);

   fa_hw_sel u_sel (
      .line (src.data),
      .idx  (pc[2:1]),
      .lo   (lo),
      .word (word)
   );

   assign fetch_misalign = pc[0];
   assign cross_wait     = (state_q == S_CROSS);

   // Outputs are gated by reset so a stale hit cannot leak while the core is held
   always_comb begin
      rv32_instr = NOP_INSTR;
      isrv16     = 1'b0;
      inst_valid = 1'b0;
      if (cpurst_n && !pc[0]) begin
         if (state_q == S_IDLE) begin
            if (hit && is_rv16(lo)) begin
               rv32_instr = {16'h0, lo};
               isrv16     = 1'b1;
               inst_valid = 1'b1;
            end else if (hit && pc[2:1] != 2'b11) begin
               rv32_instr = word;
               inst_valid = 1'b1;
            end
         end else if (!drop && xhit) begin
            rv32_instr = {src.data[15:0], hold_hw_q};
            inst_valid = 1'b1;
         end
      end
   end

   // Line buffer keeps capturing under pipe_hold; a mispredict invalidates it
   always_ff @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n) begin
         line_q <= '{data: 64'h0, tag: RST_ADR, vld: 1'b0};
      end else if (branch_predict_err) begin
         line_q.vld <= 1'b0;
      end else if (isram_cs_ff) begin
         line_q <= src;
      end
   end

   always_ff @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n) begin
         state_q   <= S_IDLE;
         hold_hw_q <= 16'h0;
      end else if (drop) begin
         state_q <= S_IDLE;
      end else if (!pipe_hold) begin
         unique case (state_q)
            S_IDLE: begin
               if (cross_go) begin
                  hold_hw_q <= lo;
                  state_q   <= S_CROSS;
               end
            end
            S_CROSS: begin
               if (xhit) state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: directed scenarios plus randomized traffic against a halfword-level model.
module tb_fetch_align;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        cpurst_n;
   logic [31:0] pc;
   logic [63:0] isram_rdata;
   logic        isram_cs_ff;
   logic [28:0] isram_adr_ff;
   logic        fet_flush;
   logic        branch_predict_err;
   logic        pipe_hold;
   logic [31:0] rv32_instr;
   logic        isrv16;
   logic        inst_valid;
   logic        fetch_misalign;
   logic        cross_wait;

   int checks   = 0;
   int failures = 0;

   fetch_align dut (
      .clk                (clk),
      .cpurst_n           (cpurst_n),
      .pc                 (pc),
      .isram_rdata        (isram_rdata),
      .isram_cs_ff        (isram_cs_ff),
      .isram_adr_ff       (isram_adr_ff),
      .fet_flush          (fet_flush),
      .branch_predict_err (branch_predict_err),
      .pipe_hold          (pipe_hold),
      .rv32_instr         (rv32_instr),
      .isrv16             (isrv16),
      .inst_valid         (inst_valid),
      .fetch_misalign     (fetch_misalign),
      .cross_wait         (cross_wait)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: memory seen as halfwords at byte addresses pc and pc+2
   logic [63:0] m_data;
   logic [28:0] m_tag;
   logic        m_vld;
   logic        m_pend;
   logic [15:0] m_hw;

   logic [63:0] s_data;
   logic [28:0] s_tag;
   logic        s_vld;
   logic [31:0] a2;
   logic [15:0] h0, h1;
   logic        c0, c1;
   logic [31:0] exp_ins;
   logic        exp_16, exp_vld, exp_start;

   always_comb begin
      s_data    = isram_cs_ff ? isram_rdata  : m_data;
      s_tag     = isram_cs_ff ? isram_adr_ff : m_tag;
      s_vld     = isram_cs_ff | m_vld;
      a2        = pc + 32'd2;
      c0        = s_vld && (s_tag == pc[31:3]);
      c1        = s_vld && (s_tag == a2[31:3]);
      h0        = 16'(s_data >> {pc[2:1], 4'b0000});
      h1        = 16'(s_data >> {a2[2:1], 4'b0000});
      exp_ins   = NOP;
      exp_16    = 1'b0;
      exp_vld   = 1'b0;
      exp_start = 1'b0;
      if (cpurst_n && !pc[0]) begin
         if (m_pend) begin
            if (!branch_predict_err && !fet_flush && c1) begin
               exp_ins = {h1, m_hw};
               exp_vld = 1'b1;
            end
         end else if (c0) begin
            if (h0[1:0] != 2'b11) begin
               exp_ins = {16'h0, h0};
               exp_16  = 1'b1;
               exp_vld = 1'b1;
            end else if (a2[31:3] == pc[31:3]) begin
               exp_ins = {h1, h0};
               exp_vld = 1'b1;
            end else begin
               exp_start = 1'b1;
            end
         end
      end
   end

   always @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n) begin
         m_data <= '0; m_tag <= '0; m_vld <= 1'b0; m_pend <= 1'b0; m_hw <= '0;
      end else begin
         if (branch_predict_err) m_vld <= 1'b0;
         else if (isram_cs_ff) begin
            m_data <= isram_rdata; m_tag <= isram_adr_ff; m_vld <= 1'b1;
         end
         if (branch_predict_err || fet_flush) m_pend <= 1'b0;
         else if (!pipe_hold) begin
            if (m_pend && exp_vld) m_pend <= 1'b0;
            else if (!m_pend && exp_start) begin
               m_pend <= 1'b1; m_hw <= h0;
            end
         end
      end
   end

   task automatic test_reset();
      cpurst_n = 1'b0; pc = 32'h100; isram_cs_ff = 1'b1; isram_adr_ff = 29'h20;
      isram_rdata = 64'h0000_0000_0050_0093;
      fet_flush = 1'b0; branch_predict_err = 1'b0; pipe_hold = 1'b0;
      #12;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", inst_valid); end
      checks++; if (rv32_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", rv32_instr, NOP); end
      checks++; if (isrv16 !== 1'b0) begin failures++; $display("FAIL reset_rv16 got=%0h exp=0", isrv16); end
      checks++; if (cross_wait !== 1'b0) begin failures++; $display("FAIL reset_cross got=%0h exp=0", cross_wait); end
      pc = 32'h101; #1;
      checks++; if (fetch_misalign !== 1'b1) begin failures++; $display("FAIL reset_misalign got=%0h exp=1", fetch_misalign); end
      @(negedge clk); cpurst_n = 1'b1;
   endtask

   task automatic test_aligned();
      @(negedge clk);
      pc = 32'h100; isram_cs_ff = 1'b1; isram_adr_ff = 29'h20;
      isram_rdata = {16'h0293, 16'h4505, 32'h0050_0093};
      #1;
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%0h exp=1", inst_valid); end
      checks++; if (isrv16 !== 1'b0) begin failures++; $display("FAIL full_rv16 got=%0h exp=0", isrv16); end
      checks++; if (rv32_instr !== 32'h0050_0093) begin failures++; $display("FAIL full_instr got=%h exp=00500093", rv32_instr); end
      @(negedge clk);
      pc = 32'h104; isram_cs_ff = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL reuse_valid got=%0h exp=1", inst_valid); end
      checks++; if (isrv16 !== 1'b1) begin failures++; $display("FAIL reuse_rv16 got=%0h exp=1", isrv16); end
      checks++; if (rv32_instr !== 32'h0000_4505) begin failures++; $display("FAIL reuse_instr got=%h exp=00004505", rv32_instr); end
   endtask

   task automatic test_cross();
      @(negedge clk);
      pc = 32'h106; #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL cross_start_valid got=%0h exp=0", inst_valid); end
      checks++; if (cross_wait !== 1'b0) begin failures++; $display("FAIL cross_start_wait got=%0h exp=0", cross_wait); end
      @(negedge clk);
      isram_cs_ff = 1'b1; isram_adr_ff = 29'h21; isram_rdata = 64'h0293_0000_0000_0010; #1;
      checks++; if (cross_wait !== 1'b1) begin failures++; $display("FAIL cross_wait got=%0h exp=1", cross_wait); end
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL cross_done_valid got=%0h exp=1", inst_valid); end
      checks++; if (rv32_instr !== 32'h0010_0293) begin failures++; $display("FAIL cross_done_instr got=%h exp=00100293", rv32_instr); end
      @(negedge clk);
      isram_cs_ff = 1'b0; pc = 32'h10E; #1;
      checks++; if (cross_wait !== 1'b0) begin failures++; $display("FAIL cross_back_idle got=%0h exp=0", cross_wait); end
   endtask

   task automatic test_redirect();
      @(negedge clk);
      branch_predict_err = 1'b1; #1;
      checks++; if (cross_wait !== 1'b1) begin failures++; $display("FAIL bpe_in_cross got=%0h exp=1", cross_wait); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL bpe_valid got=%0h exp=0", inst_valid); end
      @(negedge clk);
      branch_predict_err = 1'b0; #1;
      checks++; if (cross_wait !== 1'b0) begin failures++; $display("FAIL bpe_exit got=%0h exp=0", cross_wait); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL bpe_line_inval got=%0h exp=0", inst_valid); end
      checks++; if (rv32_instr !== NOP) begin failures++; $display("FAIL bpe_nop got=%h exp=%h", rv32_instr, NOP); end
   endtask

   task automatic test_misalign_wrap();
      @(negedge clk);
      pc = 32'h103; #1;
      checks++; if (fetch_misalign !== 1'b1) begin failures++; $display("FAIL misalign got=%0h exp=1", fetch_misalign); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL misalign_valid got=%0h exp=0", inst_valid); end
      @(negedge clk);
      pc = 32'hFFFF_FFFE; isram_cs_ff = 1'b1; isram_adr_ff = 29'h1FFF_FFFF;
      isram_rdata = 64'h0513_0000_0000_0000; #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL wrap_start_valid got=%0h exp=0", inst_valid); end
      checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL wrap_misalign got=%0h exp=0", fetch_misalign); end
      @(negedge clk);
      isram_cs_ff = 1'b0; #1;
      checks++; if (cross_wait !== 1'b1) begin failures++; $display("FAIL wrap_wait got=%0h exp=1", cross_wait); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL wrap_wait_valid got=%0h exp=0", inst_valid); end
      @(negedge clk);
      isram_cs_ff = 1'b1; isram_adr_ff = 29'h0; isram_rdata = 64'h0000_0000_0000_00A0; #1;
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL wrap_done_valid got=%0h exp=1", inst_valid); end
      checks++; if (rv32_instr !== 32'h00A0_0513) begin failures++; $display("FAIL wrap_done_instr got=%h exp=00a00513", rv32_instr); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      pc = 32'hFFFF_FFFE; isram_cs_ff = 1'b1; isram_adr_ff = 29'h1FFF_FFFF;
      isram_rdata = 64'h0513_0000_0000_0000;
      @(negedge clk);
      isram_cs_ff = 1'b0; #1;
      checks++; if (cross_wait !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0h exp=1", cross_wait); end
      #1 cpurst_n = 1'b0; #1;
      checks++; if (cross_wait !== 1'b0) begin failures++; $display("FAIL areset_cross got=%0h exp=0", cross_wait); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0h exp=0", inst_valid); end
      @(negedge clk);
      cpurst_n = 1'b1; pc = 32'h0; #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL areset_after_valid got=%0h exp=0", inst_valid); end
      checks++; if (cross_wait !== 1'b0) begin failures++; $display("FAIL areset_after_cross got=%0h exp=0", cross_wait); end
   endtask

   task automatic test_random();
      logic [28:0] tag;
      logic        chg;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         chg = !m_pend || ($urandom_range(0, 7) == 0);
         if (chg) begin
            case ($urandom_range(0, 4))
               0: tag = 29'h20;
               1: tag = 29'h21;
               2: tag = 29'h22;
               3: tag = 29'h1FFF_FFFF;
               default: tag = 29'h0;
            endcase
            pc = {tag, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0)};
         end
         fet_flush          = (chg && m_pend) || ($urandom_range(0, 9) == 0);
         branch_predict_err = ($urandom_range(0, 15) == 0);
         pipe_hold          = ($urandom_range(0, 4) == 0);
         isram_cs_ff        = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0: isram_adr_ff = pc[31:3];
            1: isram_adr_ff = pc[31:3] + 29'd1;
            default: isram_adr_ff = 29'h20 + 29'($urandom_range(0, 2));
         endcase
         isram_rdata = {$urandom, $urandom};
         #1;
         checks++; if (inst_valid !== exp_vld) begin failures++; $display("FAIL rnd_valid i=%0d pc=%h got=%0h exp=%0h", i, pc, inst_valid, exp_vld); end
         checks++; if (rv32_instr !== exp_ins) begin failures++; $display("FAIL rnd_instr i=%0d pc=%h got=%h exp=%h", i, pc, rv32_instr, exp_ins); end
         checks++; if (isrv16 !== exp_16) begin failures++; $display("FAIL rnd_rv16 i=%0d pc=%h got=%0h exp=%0h", i, pc, isrv16, exp_16); end
         checks++; if (cross_wait !== m_pend) begin failures++; $display("FAIL rnd_cross i=%0d pc=%h got=%0h exp=%0h", i, pc, cross_wait, m_pend); end
         checks++; if (fetch_misalign !== pc[0]) begin failures++; $display("FAIL rnd_misalign i=%0d pc=%h got=%0h exp=%0h", i, pc, fetch_misalign, pc[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_cross();
      test_redirect();
      test_misalign_wrap();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
